lcd_text_driver: RTL and testbench

- Parametrised HD44780-class character LCD driver in 8-bit mode, write-only.
- Runs a power-on wait and an init command sequence, then idles with a ready/start handshake.
- On request, writes a full frame of LINES x CHARS characters, or clears the display.
- Sits between the CPU display path, which presents the text frame, and the LCD pins.

---
 rtl/lcd_text_driver.sv | 119 +++++++++++
 tb/tb_lcd_text_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_driver.sv
// HD44780-class character LCD driver in 8-bit write-only mode: power-on wait, init sequence, then full-frame writes or clears.
// Every transfer holds lcd_en high for T_EN cycles and low for T_GAP cycles; requests are taken only while ready=1.
module lcd_text_driver #(
  parameter int CHARS = 16,
  parameter int LINES = 2,
  parameter int T_EN  = 50_000,
  parameter int T_GAP = 50_000,
  parameter int T_PWR = 750_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear_req,
  input  logic [LINES*CHARS*8-1:0] text,
  output logic                     ready,
  output logic                     done,
  output logic [7:0]               lcd_data,
  output logic                     lcd_en,
  output logic                     lcd_rw,
  output logic                     lcd_rs
);

  localparam int T     = T_EN + T_GAP;
  localparam int CMAX  = (T_PWR > T) ? T_PWR : T;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int NSTEP = (LINES == 2) ? (2 + 2 * CHARS) : (1 + CHARS);
  localparam int SW    = $clog2(NSTEP + 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, CLR, FRAME} state_t;

  state_t                     state, next_state;
  logic [CW-1:0]              cnt;
  logic [SW-1:0]              step;
  logic [LINES*CHARS*8-1:0]   frame_q;
  logic                       done_q;
  logic                       in_xfer;
  logic                       xfer_end;

  assign in_xfer  = (state == INIT) || (state == CLR) || (state == FRAME);
  assign xfer_end = in_xfer && (cnt == CW'(T - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PWR_WAIT;
      cnt     <= '0;
      step    <= '0;
      frame_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state  <= next_state;
      done_q <= ((state == CLR) || (state == FRAME)) && (next_state == IDLE);
      if (state != next_state || xfer_end) begin
        cnt <= '0;
      end else if (state == PWR_WAIT || in_xfer) begin
        cnt <= cnt + CW'(1);
      end
      if (state != next_state) begin
        step <= '0;
      end else if (xfer_end) begin
        step <= step + SW'(1);
      end
      // Only the latched copy feeds the frame, so text may change freely once accepted.
      if (state == IDLE && start && !clear_req) begin
        frame_q <= text;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      PWR_WAIT: if (cnt == CW'(T_PWR - 1)) next_state = INIT;
      INIT:     if (xfer_end && step == SW'(3)) next_state = IDLE;
      IDLE: begin
        if (clear_req)  next_state = CLR;
        else if (start) next_state = FRAME;
      end
      CLR:      if (xfer_end) next_state = IDLE;
      FRAME:    if (xfer_end && step == SW'(NSTEP - 1)) next_state = IDLE;
      default:  next_state = PWR_WAIT;
    endcase
  end

  always_comb begin
    int ci;
    ci       = 0;
    ready    = (state == IDLE);
    done     = done_q;
    lcd_rw   = 1'b0;
    lcd_en   = in_xfer && (cnt < CW'(T_EN));
    lcd_rs   = 1'b0;
    lcd_data = 8'h00;
    unique case (state)
      INIT: begin
        case (step)
          SW'(0):  lcd_data = (LINES == 2) ? 8'h38 : 8'h30;
          SW'(1):  lcd_data = 8'h0C;
          SW'(2):  lcd_data = 8'h01;
          default: lcd_data = 8'h06;
        endcase
      end
      CLR: lcd_data = 8'h01;
      FRAME: begin
        if (step == '0) begin
          lcd_data = 8'h80;
        end else if (LINES == 2 && int'(step) == CHARS + 1) begin
          lcd_data = 8'hC0;
        end else begin
          // Second-line characters sit one step further on, behind the 0xC0 address command.
          ci       = (LINES == 2 && int'(step) > CHARS + 1) ? int'(step) - 2 : int'(step) - 1;
          lcd_rs   = 1'b1;
          lcd_data = frame_q[8*ci +: 8];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench for lcd_text_driver: expected {rs,data} bytes are queued as stimulus is driven and popped at each lcd_en rise.
module tb_lcd_text_driver;
  localparam int CHARS = 2;
  localparam int LINES = 2;
  localparam int T_EN  = 4;
  localparam int T_GAP = 3;
  localparam int T_PWR = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clear_req = 1'b0;
  logic [31:0] text = 32'h0;
  logic        ready, done, lcd_en, lcd_rw, lcd_rs;
  logic [7:0]  lcd_data;

  int checks = 0;
  int errors = 0;
  int xfer_count = 0;
  logic [8:0] exp_q[$];

  lcd_text_driver #(.CHARS(CHARS), .LINES(LINES), .T_EN(T_EN), .T_GAP(T_GAP), .T_PWR(T_PWR)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_req(clear_req), .text(text),
    .ready(ready), .done(done), .lcd_data(lcd_data), .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs)
  );

  always #5 clk = ~clk;

  // Transfer monitor: byte/rs at each rise, stability while high, high width, gap width inside a sequence.
  logic       prev_en = 1'b0;
  int         hi = 0;
  int         lo = 0;
  logic       gap_chk = 1'b0;
  logic [8:0] cur = 9'h0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0; hi = 0; lo = 0; gap_chk = 1'b0;
    end else begin
      if (lcd_en && !prev_en) begin
        if (gap_chk) begin
          checks++;
          if (lo !== T_GAP) begin errors++; $display("FAIL gap_width got %0d want %0d", lo, T_GAP); end
        end
        xfer_count++;
        cur = {lcd_rs, lcd_data};
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_xfer got rs=%0b data=%02h want none", lcd_rs, lcd_data);
        end else begin
          e = exp_q.pop_front();
          if ({lcd_rs, lcd_data} !== e)
            begin errors++; $display("FAIL xfer_byte got rs=%0b data=%02h want rs=%0b data=%02h", lcd_rs, lcd_data, e[8], e[7:0]); end
        end
        hi = 1;
      end else if (lcd_en) begin
        hi++;
        checks++;
        if ({lcd_rs, lcd_data} !== cur || lcd_rw !== 1'b0)
          begin errors++; $display("FAIL hold_stable got rs=%0b data=%02h rw=%0b want %03h rw=0", lcd_rs, lcd_data, lcd_rw, cur); end
      end else if (prev_en) begin
        checks++;
        if (hi !== T_EN) begin errors++; $display("FAIL en_width got %0d want %0d", hi, T_EN); end
        lo = 1;
        gap_chk = (exp_q.size() != 0);
      end else begin
        lo++;
      end
      prev_en = lcd_en;
    end
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame(input logic [31:0] t);
    exp_q.push_back({1'b0, 8'h80}); exp_q.push_back({1'b1, t[7:0]});   exp_q.push_back({1'b1, t[15:8]});
    exp_q.push_back({1'b0, 8'hC0}); exp_q.push_back({1'b1, t[23:16]}); exp_q.push_back({1'b1, t[31:24]});
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s pending=%0d want 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  // Counts cycles from the first post-acceptance sample until done; returns -1 on timeout.
  task automatic wait_done(output int c, output logic rdy);
    c = 0;
    while (!done && c < 200) begin @(negedge clk); c++; end
    rdy = ready;
    if (!done) c = -1;
  endtask

  task automatic test_reset();
    int c, rise;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_data, lcd_en, lcd_rw, lcd_rs, ready, done} !== 13'h0)
      begin errors++; $display("FAIL reset_outputs got %04h want 0000", {lcd_data, lcd_en, lcd_rw, lcd_rs, ready, done}); end
    push_init();
    rst = 1'b0;
    c = 0; rise = -1;
    while (!ready && c < 200) begin
      @(negedge clk); c++;
      if (lcd_en && rise < 0) rise = c;
    end
    checks++;
    if (rise !== T_PWR) begin errors++; $display("FAIL pwr_wait first_en=%0d want %0d", rise, T_PWR); end
    checks++;
    if (c !== 38) begin errors++; $display("FAIL ready_rise got cycle %0d want 38", c); end
    check_queue_empty("init_bytes");
  endtask

  task automatic test_frame();
    int c; logic rdy;
    push_frame(32'h44_43_42_41);
    text = 32'h44_43_42_41; start = 1'b1;
    @(negedge clk);
    start = 1'b0; text = 32'h0;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL frame_ready_drop got %0b want 0", ready); end
    wait_done(c, rdy);
    checks++;
    if (c !== 42) begin errors++; $display("FAIL frame_latency got %0d want 42", c); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL frame_done_ready got %0b want 1", rdy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b want 0", done); end
    check_queue_empty("frame_bytes");
  endtask

  task automatic test_clear_priority();
    int c, base; logic rdy;
    base = xfer_count;
    exp_q.push_back({1'b0, 8'h01});
    text = 32'h5A_5A_5A_5A; start = 1'b1; clear_req = 1'b1;
    @(negedge clk);
    start = 1'b0; clear_req = 1'b0;
    wait_done(c, rdy);
    checks++;
    if (c !== 7) begin errors++; $display("FAIL clear_latency got %0d want 7", c); end
    repeat (20) @(negedge clk);
    checks++;
    if (xfer_count - base !== 1) begin errors++; $display("FAIL clear_xfers got %0d want 1", xfer_count - base); end
    check_queue_empty("clear_bytes");
  endtask

  task automatic test_back_to_back();
    int c, base; logic rdy;
    base = xfer_count;
    push_frame(32'h88_77_66_55);
    text = 32'h88_77_66_55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    text = 32'h11_22_33_44; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c, rdy);
    checks++;
    if (c !== 22) begin errors++; $display("FAIL midstart_latency got %0d want 22", c); end
    repeat (40) @(negedge clk);
    checks++;
    if (xfer_count - base !== 6) begin errors++; $display("FAIL midstart_xfers got %0d want 6", xfer_count - base); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL midstart_idle got ready=%0b want 1", ready); end
    check_queue_empty("midstart_bytes");
  endtask

  task automatic test_reset_mid_frame();
    int c, base;
    base = xfer_count;
    push_frame(32'hA4_A3_A2_A1);
    text = 32'hA4_A3_A2_A1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (xfer_count - base < 3 && c < 200) begin @(negedge clk); c++; end
    checks++;
    if (xfer_count - base !== 3) begin errors++; $display("FAIL third_xfer_seen got %0d want 3", xfer_count - base); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_en !== 1'b0 || ready !== 1'b0)
      begin errors++; $display("FAIL reset_midframe got en=%0b ready=%0b want 0 0", lcd_en, ready); end
    exp_q.delete();
    push_init();
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    while (!ready && c < 200) begin @(negedge clk); c++; end
    checks++;
    if (c !== 38) begin errors++; $display("FAIL rerun_ready got cycle %0d want 38", c); end
    check_queue_empty("rerun_init_bytes");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
